// File: rtl/uart_tx_if.sv
// uart_tx_if: parallel request side and serial line of the UART transmitter.
// The requester (master) drives the byte, framing options and prescale;
// the transmitter (slave) drives the serial line and its busy flag.
interface uart_tx_if #(
   parameter int DATA_WIDTH     = 8,
   parameter int PRESCALE_WIDTH = 5
);
   logic [DATA_WIDTH-1:0]     P_Data;
   logic                      Data_valid;
   logic                      Parity_EN;
   logic                      Parity_type;
   logic [PRESCALE_WIDTH-1:0] Prescale;
   logic                      S_Data;
   logic                      Busy;

   modport master (
      output P_Data, Data_valid, Parity_EN, Parity_type, Prescale,
      input  S_Data, Busy
   );

   modport slave (
      input  P_Data, Data_valid, Parity_EN, Parity_type, Prescale,
      output S_Data, Busy
   );
endinterface

// File: rtl/uart_tx.sv
// uart_tx: serial UART transmitter. A request is taken from IDLE, the frame
// options are latched, and a frame of start bit, LSB-first data bits,
// optional parity bit and stop bit(s) is shifted out, each bit lasting
// Prescale clock cycles (a Prescale of 0 behaves as 1).
// Optional build macro: UART_TX_TWO_STOP_EN -- send two stop bits instead of one.
module uart_tx #(
   parameter int DATA_WIDTH     = 8,
   parameter int PRESCALE_WIDTH = 5
) (
   input logic     CLK,
   input logic     Reset,
   uart_tx_if.slave bus
);

   localparam int BIT_CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
   localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(DATA_WIDTH - 1);

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

   state_t                    state, state_next;
   logic [DATA_WIDTH-1:0]     data_q;
   logic                      par_en_q;
   logic                      par_type_q;
   logic [PRESCALE_WIDTH-1:0] presc_q;
   logic [PRESCALE_WIDTH-1:0] presc_cnt, presc_cnt_next;
   logic [PRESCALE_WIDTH-1:0] p_eff;
   logic [BIT_CNT_W-1:0]      bit_cnt, bit_cnt_next, bit_cnt_inc;
   logic                      s_data_q, s_data_next;
   logic                      busy_q;
   logic                      accept;
   logic                      bit_end;
   logic                      parity_bit;
`ifdef UART_TX_TWO_STOP_EN
   logic                      stop_cnt, stop_cnt_next;
`endif

   assign accept      = (state == IDLE) && bus.Data_valid;
   assign p_eff       = (presc_q == '0) ? PRESCALE_WIDTH'(1) : presc_q;
   assign bit_end     = (presc_cnt == (p_eff - PRESCALE_WIDTH'(1)));
   assign bit_cnt_inc = bit_cnt + 1'b1;
   assign parity_bit  = (^data_q) ^ par_type_q;

   assign bus.S_Data  = s_data_q;
   assign bus.Busy    = busy_q;

   // State, counters and the serial-line register; the line value is decided
   // one cycle ahead so the pin comes straight from a flop.
   always_ff @(posedge CLK) begin
      if (Reset) begin
         state      <= IDLE;
         s_data_q   <= 1'b1;
         busy_q     <= 1'b0;
         presc_cnt  <= '0;
         bit_cnt    <= '0;
         data_q     <= '0;
         par_en_q   <= 1'b0;
         par_type_q <= 1'b0;
         presc_q    <= '0;
`ifdef UART_TX_TWO_STOP_EN
         stop_cnt   <= 1'b0;
`endif
      end else begin
         state     <= state_next;
         s_data_q  <= s_data_next;
         busy_q    <= (state_next != IDLE);
         presc_cnt <= presc_cnt_next;
         bit_cnt   <= bit_cnt_next;
`ifdef UART_TX_TWO_STOP_EN
         stop_cnt  <= stop_cnt_next;
`endif
         if (accept) begin
            data_q     <= bus.P_Data;
            par_en_q   <= bus.Parity_EN;
            par_type_q <= bus.Parity_type;
            presc_q    <= bus.Prescale;
         end
      end
   end

   // Next state, next counter values and the next serial-line value.
   always_comb begin
      state_next     = state;
      presc_cnt_next = presc_cnt;
      bit_cnt_next   = bit_cnt;
      s_data_next    = s_data_q;
`ifdef UART_TX_TWO_STOP_EN
      stop_cnt_next  = stop_cnt;
`endif
      case (state)
         IDLE: begin
            s_data_next = 1'b1;
            if (bus.Data_valid) begin
               state_next     = START;
               presc_cnt_next = '0;
               bit_cnt_next   = '0;
               s_data_next    = 1'b0;
            end
         end
         START: begin
            if (bit_end) begin
               state_next     = DATA;
               presc_cnt_next = '0;
               bit_cnt_next   = '0;
               s_data_next    = data_q[0];
            end else begin
               presc_cnt_next = presc_cnt + 1'b1;
            end
         end
         DATA: begin
            if (bit_end) begin
               presc_cnt_next = '0;
               if (bit_cnt == LAST_BIT) begin
                  if (par_en_q) begin
                     state_next  = PARITY;
                     s_data_next = parity_bit;
                  end else begin
                     state_next  = STOP;
                     s_data_next = 1'b1;
`ifdef UART_TX_TWO_STOP_EN
                     stop_cnt_next = 1'b0;
`endif
                  end
               end else begin
                  bit_cnt_next = bit_cnt_inc;
                  s_data_next  = data_q[bit_cnt_inc];
               end
            end else begin
               presc_cnt_next = presc_cnt + 1'b1;
            end
         end
         PARITY: begin
            if (bit_end) begin
               state_next     = STOP;
               presc_cnt_next = '0;
               s_data_next    = 1'b1;
`ifdef UART_TX_TWO_STOP_EN
               stop_cnt_next  = 1'b0;
`endif
            end else begin
               presc_cnt_next = presc_cnt + 1'b1;
            end
         end
         STOP: begin
            s_data_next = 1'b1;
            if (bit_end) begin
               presc_cnt_next = '0;
`ifdef UART_TX_TWO_STOP_EN
               if (stop_cnt == 1'b0) begin
                  stop_cnt_next = 1'b1;
               end else begin
                  state_next = IDLE;
               end
`else
               state_next = IDLE;
`endif
            end else begin
               presc_cnt_next = presc_cnt + 1'b1;
            end
         end
         default: begin
            state_next  = IDLE;
            s_data_next = 1'b1;
         end
      endcase
   end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, number of data bits per frame.
REQ-002 SHALL have parameter PRESCALE_WIDTH, default 5, width of the Prescale input.
REQ-003 SHALL have port CLK  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port Reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port P_Data  input  DATA_WIDTH  parallel byte to transmit.
REQ-006 SHALL have port Data_valid  input  1  request to send P_Data; taken only when Busy=0.
REQ-007 SHALL have port Parity_EN  input  1  1 = insert a parity bit after the data bits.
REQ-008 SHALL have port Parity_type  input  1  0 = even parity, 1 = odd parity.
REQ-009 SHALL have port Prescale  input  PRESCALE_WIDTH  CLK cycles per serial bit.
REQ-010 SHALL have port S_Data  output  1  serial line; idles high.
REQ-011 SHALL have port Busy  output  1  high while a frame is in progress.

Function
REQ-012 SHALL use the states IDLE, START, DATA, PARITY and STOP.
REQ-013 SHALL accept a request when the state is IDLE and Data_valid=1 at a clock edge.
REQ-014 SHALL, on acceptance, latch P_Data, Parity_EN, Parity_type and Prescale; input changes after acceptance do not affect the frame.
REQ-015 SHALL ignore Data_valid while Busy=1, with no queuing.
REQ-016 SHALL, on the edge after acceptance, drive S_Data=0 (start bit) and Busy=1, with zero idle cycles between acceptance and the start bit.
REQ-017 SHALL hold each bit (start, data, parity, stop) for exactly P CLK cycles, where P is the latched Prescale, and P=0 is treated as 1.
REQ-018 SHALL send the data bits LSB first, DATA_WIDTH bits.
REQ-019 SHALL compute the parity bit as XOR of the latched data for even parity and its inverse for odd parity; the PARITY state is skipped when the latched Parity_EN=0.
REQ-020 SHALL drive the stop bit as S_Data=1.
REQ-021 SHALL, after the last stop-bit cycle, enter IDLE with Busy=0 and S_Data=1.
REQ-022 SHALL allow a new request in the first IDLE cycle, giving a minimum gap of one idle-high cycle between frames.
REQ-023 SHALL make the frame length (1 + DATA_WIDTH + Parity_EN + stop bits) * P cycles.
REQ-024 SHALL drive S_Data from a register so that it is glitch-free.
REQ-025 SHALL keep the bit counter and prescale counter wide enough for DATA_WIDTH and for P=2^PRESCALE_WIDTH-1 without wrap.

Reset
REQ-026 SHALL, on Reset=1 at a clock edge, set state=IDLE, S_Data=1, Busy=0, and clear all counters and latched data.
REQ-027 SHALL, when Reset is asserted mid-frame, abort the frame with S_Data=1 on that edge; Data_valid is ignored while Reset=1.
REQ-028 SHALL give Reset priority over every other event.

Configuration
REQ-029 SHALL, with macro UART_TX_TWO_STOP_EN defined, send two stop bits (2*P cycles high) before returning to IDLE.
REQ-030 SHALL, without UART_TX_TWO_STOP_EN, send exactly one stop bit.

Verification
REQ-031 SHALL cover: Prescale=8, Parity_EN=1, Parity_type=0, P_Data=8'hAB -> S_Data = 0,1,1,0,1,0,1,0,1,1(parity),1(stop), each 8 cycles, Busy high for 88 cycles.
REQ-032 SHALL cover: same frame with Parity_type=1 -> parity bit 0; with Parity_EN=0 -> 80-cycle frame, no parity bit.
REQ-033 SHALL cover: Data_valid pulsed with P_Data=8'h55 mid-frame -> ignored, current frame unchanged, no second frame sent.
REQ-034 SHALL cover: Data_valid held high continuously, Prescale=16 -> back-to-back frames separated by exactly one idle-high cycle.
REQ-035 SHALL cover: Reset asserted during DATA state -> next edge S_Data=1, Busy=0, and a later request transmits a full, correct frame.
REQ-036 SHALL cover: UART_TX_TWO_STOP_EN defined, Prescale=8, parity on -> 96-cycle frame with S_Data high for the final 16 cycles.
